divider_restoring: RTL and testbench

DIVIDER_RESTORING -- requirements
Module: divider_restoring

---
 rtl/divider_pkg.sv | 19 +
 rtl/divider_restoring_if.sv | 31 +++
 rtl/divider_step.sv | 22 ++
 rtl/divider_restoring.sv | 116 +++++++++++
 tb/tb_divider_restoring.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types for the restoring divider: one-hot state encoding
// and the iteration-counter sizing helper.
package divider_pkg;

  localparam int IDX_I = 0;
  localparam int IDX_C = 1;
  localparam int IDX_D = 2;

  typedef enum logic [2:0] {
    INITIAL = 3'b001,
    COMPUTE = 3'b010,
    DONE_S  = 3'b100
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divider_restoring_if.sv
// Request/result bundle between a divider user and the divider.
// The master drives operands, Start and Ack; the slave returns results.
interface divider_restoring_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] Xin;
  logic [WIDTH-1:0] Yin;
  logic             Start;
  logic             Ack;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Qi;
  logic             Qc;
  logic             Qd;

  modport master (
    output Xin, Yin, Start, Ack,
    input  Done, DivByZero, Quotient, Remainder,
    input  Qi, Qc, Qd
  );

  modport slave (
    input  Xin, Yin, Start, Ack,
    output Done, DivByZero, Quotient, Remainder,
    output Qi, Qc, Qd
  );

endinterface

// File: rtl/divider_step.sv
// One restoring division step: shift in a dividend bit, then
// subtract the divisor when the widened remainder allows it.
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  assign trial = {rem_in, dividend_bit};
  // Result is below divisor, so modular low bits are exact
  assign diff = trial[WIDTH-1:0] - divisor;
  assign quo_bit = (trial >= {1'b0, divisor});
  assign rem_out = quo_bit ? diff : trial[WIDTH-1:0];

endmodule

// File: rtl/divider_restoring.sv
// Multi-bit-per-cycle restoring divider with one-hot control FSM,
// divide-by-zero shortcut and Done/Ack result handshake.
module divider_restoring
  import divider_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input logic          Clk,
  input logic          Reset_n,
  divider_restoring_if.slave bus
);

  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = WIDTH / B;
  localparam int CW = cnt_width(N);

  if (WIDTH < 4 || WIDTH > 32 || B < 1 || (WIDTH % B) != 0) begin : g_bad
    $error("divider_restoring: illegal WIDTH/BITS_PER_CYCLE");
  end

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_q;
  logic             last;
  logic             y_zero;

  logic [WIDTH-1:0] rem_c [B+1];
  logic [B-1:0]     qb;
  logic [WIDTH-1:0] quo_n;

  assign rem_c[0] = rem_q;

  for (genvar i = 0; i < B; i++) begin : g_step
    divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_in       (rem_c[i]),
      .dividend_bit (x_q[WIDTH-1-i]),
      .divisor      (y_q),
      .rem_out      (rem_c[i+1]),
      .quo_bit      (qb[B-1-i])
    );
  end

  if (B == WIDTH) begin : g_qfull
    assign quo_n = qb;
  end else begin : g_qshift
    assign quo_n = {quo_q[WIDTH-B-1:0], qb};
  end

  assign last   = (cnt_q == CW'(N - 1));
  assign y_zero = (bus.Yin == '0);

  always_comb begin
    state_n = state;
    unique case (1'b1)
      state[IDX_I]: begin
        if (bus.Start) state_n = y_zero ? DONE_S : COMPUTE;
      end
      state[IDX_C]: begin
        if (last) state_n = DONE_S;
      end
      state[IDX_D]: begin
        if (bus.Ack) state_n = INITIAL;
      end
      default: state_n = INITIAL;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= INITIAL;
      x_q   <= '0;
      y_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      state <= state_n;
      unique case (1'b1)
        state[IDX_I]: begin
          if (bus.Start) begin
            x_q   <= bus.Xin;
            y_q   <= bus.Yin;
            cnt_q <= '0;
            dz_q  <= y_zero;
            quo_q <= y_zero ? '1 : '0;
            rem_q <= y_zero ? bus.Xin : '0;
          end
        end
        state[IDX_C]: begin
          x_q   <= x_q << B;
          rem_q <= rem_c[B];
          quo_q <= quo_n;
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Done      = state[IDX_D];
  assign bus.Qi        = state[IDX_I];
  assign bus.Qc        = state[IDX_C];
  assign bus.Qd        = state[IDX_D];
  assign bus.DivByZero = dz_q;
  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_q;

endmodule

// File: tb/tb_divider_restoring.sv
// Scoreboard bench for divider_restoring: directed and random runs
// on several WIDTH/BITS_PER_CYCLE builds against plain / and %.
module tb_divider_restoring;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic Clk;
  logic Reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb [4][$];
  logic [3:0] done_prev = '0;

  divider_restoring_if #(.WIDTH(8))  if0 ();
  divider_restoring_if #(.WIDTH(8))  if1 ();
  divider_restoring_if #(.WIDTH(8))  if2 ();
  divider_restoring_if #(.WIDTH(16)) if3 ();

  divider_restoring #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if0.slave));
  divider_restoring #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if1.slave));
  divider_restoring #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if2.slave));
  divider_restoring #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if3.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic exp_t ref_div(input int w, input logic [31:0] x,
                                   input logic [31:0] y);
    exp_t e;
    if (y == 0) begin
      e.q  = (32'd1 << w) - 32'd1;
      e.r  = x;
      e.dz = 1'b1;
    end else begin
      e.q  = x / y;
      e.r  = x % y;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic sb_cmp(input int k, input string tag,
                        input logic [31:0] q, input logic [31:0] r,
                        input logic dz);
    if (sb[k].size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected_done got=q%0h/r%0h exp=none", tag, q, r);
    end else begin
      check({tag, "_quo"}, q, sb[k][0].q);
      check({tag, "_rem"}, r, sb[k][0].r);
      check({tag, "_dz"}, {31'd0, dz}, {31'd0, sb[k][0].dz});
      void'(sb[k].pop_front());
    end
  endtask

  // Monitor: compare on each rising Done, independent of the driver
  always @(negedge Clk) begin
    if (if0.Done && !done_prev[0])
      sb_cmp(0, "w8b2", if0.Quotient, if0.Remainder, if0.DivByZero);
    if (if1.Done && !done_prev[1])
      sb_cmp(1, "w8b1", if1.Quotient, if1.Remainder, if1.DivByZero);
    if (if2.Done && !done_prev[2])
      sb_cmp(2, "w8b4", if2.Quotient, if2.Remainder, if2.DivByZero);
    if (if3.Done && !done_prev[3])
      sb_cmp(3, "w16b4", {16'd0, if3.Quotient}, {16'd0, if3.Remainder},
             if3.DivByZero);
    done_prev <= {if3.Done, if2.Done, if1.Done, if0.Done};
  end

  task automatic run8(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   lat;
    logic seen;
    e = ref_div(8, {24'd0, x}, {24'd0, y});
    @(negedge Clk);
    if0.Xin   = x;
    if0.Yin   = y;
    if0.Start = 1'b1;
    if0.Ack   = 1'b0;
    sb[0].push_back(e);
    @(posedge Clk);
    #1;
    if0.Start = 1'b0;
    if0.Xin   = 8'($urandom);
    if0.Yin   = 8'($urandom);
    lat  = 0;
    seen = if0.Done;
    while (!seen && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
      seen = if0.Done;
    end
    check("lat_w8b2", lat, (y == 0) ? 0 : 4);
    if (seen) begin
      repeat (3) @(negedge Clk);
      check("hold_done", {31'd0, if0.Done}, 32'd1);
      check("hold_quo", {24'd0, if0.Quotient}, e.q);
    end
    @(negedge Clk);
    if0.Ack = 1'b1;
    @(posedge Clk);
    #1;
    check("ack_state", {if0.Qi, if0.Qc, if0.Qd}, 3'b100);
    @(negedge Clk);
    if0.Ack = 1'b0;
  endtask

  task automatic run_aux(input logic [7:0] x8, input logic [7:0] y8,
                         input logic [15:0] x16, input logic [15:0] y16);
    int l1;
    int l2;
    int l3;
    @(negedge Clk);
    if1.Xin = x8;  if1.Yin = y8;  if1.Start = 1'b1;
    if2.Xin = x8;  if2.Yin = y8;  if2.Start = 1'b1;
    if3.Xin = x16; if3.Yin = y16; if3.Start = 1'b1;
    sb[1].push_back(ref_div(8, {24'd0, x8}, {24'd0, y8}));
    sb[2].push_back(ref_div(8, {24'd0, x8}, {24'd0, y8}));
    sb[3].push_back(ref_div(16, {16'd0, x16}, {16'd0, y16}));
    @(posedge Clk);
    #1;
    if1.Start = 1'b0; if2.Start = 1'b0; if3.Start = 1'b0;
    if1.Xin = 8'($urandom);  if1.Yin = 8'($urandom);
    if2.Xin = 8'($urandom);  if2.Yin = 8'($urandom);
    if3.Xin = 16'($urandom); if3.Yin = 16'($urandom);
    l1 = -1;
    l2 = -1;
    l3 = -1;
    for (int c = 0; c <= 24; c++) begin
      if (if1.Done && l1 < 0) l1 = c;
      if (if2.Done && l2 < 0) l2 = c;
      if (if3.Done && l3 < 0) l3 = c;
      if (l1 >= 0 && l2 >= 0 && l3 >= 0) break;
      @(posedge Clk);
      #1;
    end
    check("lat_w8b1", l1, (y8 == 0) ? 0 : 8);
    check("lat_w8b4", l2, (y8 == 0) ? 0 : 2);
    check("lat_w16b4", l3, (y16 == 0) ? 0 : 4);
    @(negedge Clk);
    if1.Ack = 1'b1; if2.Ack = 1'b1; if3.Ack = 1'b1;
    @(posedge Clk);
    #1;
    check("aux_ret", {if1.Qi, if2.Qi, if3.Qi}, 3'b111);
    @(negedge Clk);
    if1.Ack = 1'b0; if2.Ack = 1'b0; if3.Ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int comp;
    int dn;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic [15:0] x16;
    logic [15:0] y16;

    Reset_n = 1'b1;
    if0.Xin = '0; if0.Yin = '0; if0.Start = 1'b0; if0.Ack = 1'b0;
    if1.Xin = '0; if1.Yin = '0; if1.Start = 1'b0; if1.Ack = 1'b0;
    if2.Xin = '0; if2.Yin = '0; if2.Start = 1'b0; if2.Ack = 1'b0;
    if3.Xin = '0; if3.Yin = '0; if3.Start = 1'b0; if3.Ack = 1'b0;
    #1 Reset_n = 1'b0;
    #1;
    check("rst_flags", {if0.Qi, if0.Qc, if0.Qd, if0.Done, if0.DivByZero},
          5'b10000);
    check("rst_quo", {24'd0, if0.Quotient}, 32'd0);
    check("rst_rem", {24'd0, if0.Remainder}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    run8(8'd200, 8'd7);
    run8(8'd77, 8'd0);
    run8(8'd5, 8'd9);
    run8(8'd255, 8'd1);
    run8(8'd0, 8'd3);
    run8(8'd255, 8'd255);

    // Abort two cycles into COMPUTE with reset between clock edges
    @(negedge Clk);
    if0.Xin = 8'd100; if0.Yin = 8'd3; if0.Start = 1'b1;
    @(posedge Clk);
    #1;
    if0.Start = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    check("pre_rst_qc", {31'd0, if0.Qc}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_flags", {if0.Qi, if0.Qc, if0.Qd, if0.Done, if0.DivByZero},
          5'b10000);
    check("mid_rst_quo", {24'd0, if0.Quotient}, 32'd0);
    check("mid_rst_rem", {24'd0, if0.Remainder}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    run8(8'd123, 8'd10);

    // Ack held high, Start toggled while busy
    @(negedge Clk);
    if0.Xin = 8'd150; if0.Yin = 8'd11; if0.Start = 1'b1; if0.Ack = 1'b1;
    sb[0].push_back(ref_div(8, 32'd150, 32'd11));
    @(posedge Clk);
    #1;
    if0.Start = 1'b0;
    comp = 0;
    dn   = 0;
    repeat (10) begin
      @(negedge Clk);
      if (if0.Qc) comp++;
      if (if0.Done) dn++;
      if0.Start = (if0.Qc || if0.Qd) ? ~if0.Start : 1'b0;
    end
    check("ackh_compute_cycles", comp, 4);
    check("ackh_done_cycles", dn, 1);
    check("ackh_idle", {31'd0, if0.Qi}, 32'd1);
    if0.Ack = 1'b0;

    for (int i = 0; i < 30; i++) begin
      x8 = 8'($urandom_range(0, 255));
      y8 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run8(x8, y8);
    end

    run_aux(8'd200, 8'd7, 16'd65535, 16'd1);
    run_aux(8'd77, 8'd0, 16'd1000, 16'd0);
    run_aux(8'd5, 8'd9, 16'd3, 16'd65535);
    for (int i = 0; i < 25; i++) begin
      x8  = 8'($urandom_range(0, 255));
      y8  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      x16 = 16'($urandom_range(0, 65535));
      y16 = ($urandom_range(0, 7) == 0) ? 16'd0
                                        : 16'($urandom_range(1, 65535));
      run_aux(x8, y8, x16, y16);
    end

    repeat (2) @(negedge Clk);
    check("sb0_drained", sb[0].size(), 0);
    check("sb1_drained", sb[1].size(), 0);
    check("sb2_drained", sb[2].size(), 0);
    check("sb3_drained", sb[3].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
